ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection.
- Directly upstream of the execute ALU: it drives that ALU's control code and both operands.
- Latches decoded instructions, inserts bubbles on flush, and holds on stall.
- Resolves RAW hazards by forwarding from the MEM and WB stages. On a stall it refreshes its held operands, so a producer that retires during the stall is not lost.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU control code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- iClk  input  1  clock; all state updates on the rising edge
- iRst  input  1  synchronous, active-high reset
- iStall  input  1  hold E-stage contents
- iFlush  input  1  load a bubble into the E stage
- iValidD  input  1  decode slot holds a real instruction
- iAluControlD  input  OP_WIDTH  ALU operation code
- iRs1DataD  input  DATA_WIDTH  register-file read of rs1
- iRs2DataD  input  DATA_WIDTH  register-file read of rs2
- iImmExtD  input  DATA_WIDTH  sign-extended immediate
- iPcD  input  DATA_WIDTH  instruction PC
- iRs1AddrD  input  REG_ADDR_WIDTH  rs1 index
- iRs2AddrD  input  REG_ADDR_WIDTH  rs2 index
- iRdAddrD  input  REG_ADDR_WIDTH  rd index
- iAluSrcAD  input  1  1: op1 = PC; 0: op1 = rs1
- iAluSrcBD  input  1  1: op2 = immediate; 0: op2 = rs2
- iRegWriteD  input  1  instruction writes rd
- iRdAddrM  input  REG_ADDR_WIDTH  MEM-stage destination
- iRegWriteM  input  1  MEM-stage write enable
- iAluResultM  input  DATA_WIDTH  MEM-stage ALU result
- iRdAddrW  input  REG_ADDR_WIDTH  WB-stage destination
- iRegWriteW  input  1  WB-stage write enable
- iResultW  input  DATA_WIDTH  WB-stage write-back value
- oValidE  output  1  E stage holds a real instruction
- oAluControl  output  OP_WIDTH  to ALU
- oAluOp1  output  DATA_WIDTH  to ALU
- oAluOp2  output  DATA_WIDTH  to ALU
- oWriteDataE  output  DATA_WIDTH  forwarded rs2, store data
- oRdAddrE  output  REG_ADDR_WIDTH  E-stage rd
- oRegWriteE  output  1  E-stage write enable, gated by valid
- oRs1AddrE  output  REG_ADDR_WIDTH  to hazard unit
- oRs2AddrE  output  REG_ADDR_WIDTH  to hazard unit

Behaviour:
- Edge priority: iRst > iFlush > iStall > load.
- Reset and flush both produce a bubble. All E registers clear to 0: valid, control (0000 = ADD), rs data, imm, PC, addresses, srcA/srcB, regwrite.
- Outputs after a bubble:
  - oValidE = 0, oRegWriteE = 0, oAluControl = 0000.
  - oAluOp1 = oAluOp2 = oWriteDataE = 0.
  - All address outputs = 0.
- Load (no stall, no flush): every D field is captured. Latency is 1 cycle from D inputs to E outputs.
- Stall with no flush:
  - Control, addresses, imm, PC and valid are held.
  - Stored rs1/rs2 data are overwritten with the current forwarded values fwd1/fwd2 (refresh capture).
- Forwarding is combinational on the registered E addresses.
- fwd1:
  - If iRegWriteM and iRdAddrM != 0 and iRdAddrM == rs1E: iAluResultM.
  - Else if iRegWriteW and iRdAddrW != 0 and iRdAddrW == rs1E: iResultW.
  - Else the stored rs1 data.
  - MEM beats WB when both match.
- fwd2: same rule using rs2E.
- rd == 0 never forwards, so x0 reads as the stored value, which is 0 from the register file.
- Operand selection:
  - oAluOp1 = srcAE ? pcE : fwd1
  - oAluOp2 = srcBE ? immE : fwd2
  - oWriteDataE = fwd2 regardless of srcBE
- oRegWriteE = regWriteE & validE.
- Flush and stall asserted together: flush wins and the bubble is loaded.
- Reset mid-stall: bubble; the held instruction is discarded.
- No arithmetic inside the block; all data paths are DATA_WIDTH with no extension or truncation.

Test Plan:
- Reset, then load rs1=5, rs2=7, ctrl=0001, srcA=srcB=0, rd=3, regwrite=1 -> next cycle Op1=5, Op2=7, oAluControl=0001, oRegWriteE=1, oRdAddrE=3.
- E rs1=4, MEM rd=4 (regwrite) result 0x10, WB rd=4 result 0x20 -> Op1=0x10. Drop MEM regwrite -> Op1=0x20. Set rd=0 on both -> Op1 = stored value.
- srcA=1, pc=0x100, srcB=1, imm=0xFFFFFFFC, rs2 forwarded 0x55 from MEM -> Op1=0x100, Op2=0xFFFFFFFC, oWriteDataE=0x55.
- Stall 3 cycles with E rs2=9. Cycle 1: WB rd=9 value 0xAB. Cycles 2-3: no producers -> Op2 stays 0xAB through the stall and after release. D inputs changing during the stall are ignored.
- iFlush=1 with iStall=1 and a valid E instruction -> next cycle oValidE=0, oRegWriteE=0, Op1=Op2=0, oAluControl=0000.
- iRst pulsed mid-stall with valid E contents -> all outputs 0 on the next cycle; a normal load succeeds the cycle after reset deasserts.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding for the execute ALU.
// Bubbles on reset/flush, holds on stall while refreshing held operands from forwarding.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStall,
    input  logic                      iFlush,
    input  logic                      iValidD,
    input  logic [OP_WIDTH-1:0]       iAluControlD,
    input  logic [DATA_WIDTH-1:0]     iRs1DataD,
    input  logic [DATA_WIDTH-1:0]     iRs2DataD,
    input  logic [DATA_WIDTH-1:0]     iImmExtD,
    input  logic [DATA_WIDTH-1:0]     iPcD,
    input  logic [REG_ADDR_WIDTH-1:0] iRs1AddrD,
    input  logic [REG_ADDR_WIDTH-1:0] iRs2AddrD,
    input  logic [REG_ADDR_WIDTH-1:0] iRdAddrD,
    input  logic                      iAluSrcAD,
    input  logic                      iAluSrcBD,
    input  logic                      iRegWriteD,
    input  logic [REG_ADDR_WIDTH-1:0] iRdAddrM,
    input  logic                      iRegWriteM,
    input  logic [DATA_WIDTH-1:0]     iAluResultM,
    input  logic [REG_ADDR_WIDTH-1:0] iRdAddrW,
    input  logic                      iRegWriteW,
    input  logic [DATA_WIDTH-1:0]     iResultW,
    output logic                      oValidE,
    output logic [OP_WIDTH-1:0]       oAluControl,
    output logic [DATA_WIDTH-1:0]     oAluOp1,
    output logic [DATA_WIDTH-1:0]     oAluOp2,
    output logic [DATA_WIDTH-1:0]     oWriteDataE,
    output logic [REG_ADDR_WIDTH-1:0] oRdAddrE,
    output logic                      oRegWriteE,
    output logic [REG_ADDR_WIDTH-1:0] oRs1AddrE,
    output logic [REG_ADDR_WIDTH-1:0] oRs2AddrE
);

    logic                      vld_p0;
    logic [OP_WIDTH-1:0]       alu_ctrl_p0;
    logic [DATA_WIDTH-1:0]     rs1_data_p0;
    logic [DATA_WIDTH-1:0]     rs2_data_p0;
    logic [DATA_WIDTH-1:0]     imm_p0;
    logic [DATA_WIDTH-1:0]     pc_p0;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_p0;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_p0;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_p0;
    logic                      src_a_p0;
    logic                      src_b_p0;
    logic                      reg_write_p0;

    logic [DATA_WIDTH-1:0]     fwd1;
    logic [DATA_WIDTH-1:0]     fwd2;

    // MEM has the younger result, so it beats WB; x0 is never a forwarding target.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic [DATA_WIDTH-1:0]     stored,
        input logic                      wr_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic [DATA_WIDTH-1:0]     res_m,
        input logic                      wr_w,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic [DATA_WIDTH-1:0]     res_w
    );
        if (wr_m && (rd_m != '0) && (rd_m == src))
            return res_m;
        else if (wr_w && (rd_w != '0) && (rd_w == src))
            return res_w;
        else
            return stored;
    endfunction

    always_comb begin
        fwd1 = fwd_sel(rs1_addr_p0, rs1_data_p0, iRegWriteM, iRdAddrM, iAluResultM,
                       iRegWriteW, iRdAddrW, iResultW);
        fwd2 = fwd_sel(rs2_addr_p0, rs2_data_p0, iRegWriteM, iRdAddrM, iAluResultM,
                       iRegWriteW, iRdAddrW, iResultW);
    end

    // D -> E boundary
    always_ff @(posedge iClk) begin
        if (iRst || iFlush) begin
            vld_p0       <= 1'b0;
            alu_ctrl_p0  <= '0;
            rs1_data_p0  <= '0;
            rs2_data_p0  <= '0;
            imm_p0       <= '0;
            pc_p0        <= '0;
            rs1_addr_p0  <= '0;
            rs2_addr_p0  <= '0;
            rd_addr_p0   <= '0;
            src_a_p0     <= 1'b0;
            src_b_p0     <= 1'b0;
            reg_write_p0 <= 1'b0;
        end else if (iStall) begin
            // Refresh so a producer retiring during the stall is still seen afterwards.
            rs1_data_p0  <= fwd1;
            rs2_data_p0  <= fwd2;
        end else begin
            vld_p0       <= iValidD;
            alu_ctrl_p0  <= iAluControlD;
            rs1_data_p0  <= iRs1DataD;
            rs2_data_p0  <= iRs2DataD;
            imm_p0       <= iImmExtD;
            pc_p0        <= iPcD;
            rs1_addr_p0  <= iRs1AddrD;
            rs2_addr_p0  <= iRs2AddrD;
            rd_addr_p0   <= iRdAddrD;
            src_a_p0     <= iAluSrcAD;
            src_b_p0     <= iAluSrcBD;
            reg_write_p0 <= iRegWriteD;
        end
    end

    always_comb begin
        oValidE     = vld_p0;
        oAluControl = alu_ctrl_p0;
        oAluOp1     = src_a_p0 ? pc_p0 : fwd1;
        oAluOp2     = src_b_p0 ? imm_p0 : fwd2;
        oWriteDataE = fwd2;
        oRdAddrE    = rd_addr_p0;
        oRegWriteE  = reg_write_p0 & vld_p0;
        oRs1AddrE   = rs1_addr_p0;
        oRs2AddrE   = rs2_addr_p0;
    end

endmodule
